// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receive FIFO, first-word-fall-through read port, with
//               occupancy, almost-full and sticky overflow status.
//               Optional macro UART_RX_FIFO_ERR_TAG_EN buffers the rx error tag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_out,
  input  logic                     rx_done,
  input  logic                     rx_err,
  input  logic                     clear,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic                     rd_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int c_ENTRY_W = 9;
`else
  localparam int c_ENTRY_W = 8;
`endif

  logic [c_ENTRY_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_done_q;
  logic                 r_overflow;
  logic [7:0]           r_last_data;

  logic                 w_edge;
  logic                 w_push_req;
  logic                 w_full;
  logic                 w_valid;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [c_ENTRY_W-1:0] w_wdata;
  logic [c_ENTRY_W-1:0] w_head;

  assign w_edge = rx_done & ~r_done_q;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign w_push_req = w_edge;
  assign w_wdata    = {rx_err, rx_out};
`else
  // Without tag storage an errored byte is discarded before it can count as a push.
  assign w_push_req = w_edge & ~rx_err;
  assign w_wdata    = rx_out;
`endif

  assign w_full  = (r_count == c_CNT_W'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & rd_ready & ~clear;
  // When full, a push is only accepted if a pop frees the head slot in the same cycle.
  assign w_push  = w_push_req & ~clear & (~w_full | w_pop);
  assign w_drop  = w_push_req & ~clear & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done_q    <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_last_data <= 8'h00;
    end else begin
      r_done_q <= rx_done;
      if (clear) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop) begin
          r_rd_ptr    <= r_rd_ptr + c_PTR_W'(1);
          r_last_data <= w_head[7:0];
        end
        if (w_push && !w_pop)
          r_count <= r_count + c_CNT_W'(1);
        else if (w_pop && !w_push)
          r_count <= r_count - c_CNT_W'(1);
        if (w_drop)
          r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_wdata;
  end

  assign w_head = r_mem[r_rd_ptr];

  // Empty FIFO shows the last byte handed to the host rather than stale storage.
  assign rd_valid    = w_valid;
  assign rd_data     = w_valid ? w_head[7:0] : r_last_data;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign rd_err      = w_valid & w_head[8];
`else
  assign rd_err      = 1'b0;
`endif
  assign count       = r_count;
  assign almost_full = (r_count >= c_CNT_W'(AF_LEVEL));
  assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo (DEPTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_out = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_err = 1'b0;
  logic       clear = 1'b0;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_err;
  logic [4:0] count;
  logic       almost_full;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DEPTH(16), .AF_LEVEL(12)) dut (
    .clk(clk), .rst(rst), .rx_out(rx_out), .rx_done(rx_done), .rx_err(rx_err),
    .clear(clear), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_err(rd_err), .count(count), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic e);
    rx_out = b; rx_err = e; rx_done = 1'b1;
    tick();
    rx_done = 1'b0; rx_err = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h expected 0", rd_valid); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0h expected 0", overflow); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h expected 00", rd_data); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %0h expected 0", almost_full); end
    rst = 1'b1;
    tick();
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b0);
    n_checks++; if (count !== 5'd3) begin n_fail++; $display("FAIL midreset_pre: got %0d expected 3", count); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_async: got count %0d valid %0h expected 0 0", count, rd_valid); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    rx_out = 8'hA5; rx_done = 1'b1;
    tick();
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_latency: got valid %0h data %0h expected 1 a5", rd_valid, rd_data); end
    repeat (4) tick();
    rx_done = 1'b0;
    tick();
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
    pop_one();
    n_checks++; if (count !== 5'd0 || rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_hold: got count %0d data %0h expected 0 a5", count, rd_data); end
  endtask

  task automatic test_fill_overflow();
    int bad;
    for (int i = 0; i < 17; i++) begin
      push_byte(8'(i), 1'b0);
      if (i == 10) begin
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL af_11: got %0h expected 0", almost_full); end
      end
      if (i == 11) begin
        n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL af_12: got %0h expected 1", almost_full); end
      end
      if (i == 15) begin
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_16: got %0h expected 0", overflow); end
      end
    end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d expected 16", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %0h expected 1", overflow); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        bad++;
        $display("FAIL drain_%0d: got valid %0h data %0h expected 1 %0h", i, rd_valid, rd_data, i);
      end
      pop_one();
    end
    n_checks++; if (bad != 0) n_fail++;
    n_checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL drain_empty: got valid %0h count %0d expected 0 0", rd_valid, count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0h expected 1", overflow); end
    do_clear();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0h expected 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    int bad;
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), 1'b0);
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL pp_full: got %0d expected 16", count); end
    rx_out = 8'h77; rx_done = 1'b1; rd_ready = 1'b1;
    tick();
    rx_done = 1'b0; rd_ready = 1'b0;
    n_checks++; if (count !== 5'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL pp_both: got count %0d ovf %0h expected 16 0", count, overflow); end
    tick();
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (rd_data !== 8'h21 + 8'(i)) begin
        bad++;
        $display("FAIL pp_drain_%0d: got %0h expected %0h", i, rd_data, 8'h21 + i);
      end
      pop_one();
    end
    n_checks++; if (bad != 0) n_fail++;
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h77 || count !== 5'd1) begin n_fail++; $display("FAIL pp_last: got valid %0h data %0h count %0d expected 1 77 1", rd_valid, rd_data, count); end
    pop_one();
  endtask

  task automatic test_clear_priority();
    for (int i = 0; i < 4; i++) push_byte(8'h40 + 8'(i), 1'b0);
    n_checks++; if (count !== 5'd4) begin n_fail++; $display("FAIL clr_pre: got %0d expected 4", count); end
    rx_out = 8'h55; rx_done = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (count !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL clr_prio: got count %0d valid %0h ovf %0h expected 0 0 0", count, rd_valid, overflow); end
    tick();
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL clr_noretrig: got %0d expected 0", count); end
    rx_done = 1'b0;
    tick();
    push_byte(8'h66, 1'b0);
    n_checks++; if (count !== 5'd1 || rd_data !== 8'h66) begin n_fail++; $display("FAIL clr_next: got count %0d data %0h expected 1 66", count, rd_data); end
    pop_one();
  endtask

  task automatic test_err_tag();
    push_byte(8'h3C, 1'b1);
`ifdef UART_RX_FIFO_ERR_TAG_EN
    n_checks++; if (count !== 5'd1 || rd_data !== 8'h3C || rd_err !== 1'b1) begin n_fail++; $display("FAIL err_tag: got count %0d data %0h err %0h expected 1 3c 1", count, rd_data, rd_err); end
    pop_one();
`else
    n_checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL err_drop: got count %0d valid %0h expected 0 0", count, rd_valid); end
`endif
    rd_ready = 1'b1;
    rx_out = 8'h3D; rx_err = 1'b0; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    n_checks++; if (count !== 5'd1 || rd_data !== 8'h3D || rd_err !== 1'b0) begin n_fail++; $display("FAIL empty_push_ready: got count %0d data %0h err %0h expected 1 3d 0", count, rd_data, rd_err); end
    tick();
    rd_ready = 1'b0;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL empty_push_pop: got %0d expected 0", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_clear_priority();
    test_err_tag();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
